// File: rtl/io_poll_master.sv
// rtl/io_poll_master.sv - io_bus initiator running the switch-to-display driver loop in hardware
// Moore FSM: bus outputs decode from the registered state so async reset silences the bus at once.
module io_poll_master #(
    parameter int DATA_WIDTH  = 32,
    parameter int RDY_TIMEOUT = 1000000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  clr,
    output logic [7:0]            io_addr,
    output logic [DATA_WIDTH-1:0] io_dout,
    input  logic [DATA_WIDTH-1:0] io_din,
    output logic                  io_we,
    output logic                  io_rd,
    output logic                  busy,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] acc,
    output logic [15:0]           count
);

    localparam logic [7:0] ADDR_LED  = 8'h00;
    localparam logic [7:0] ADDR_RDY  = 8'h08;
    localparam logic [7:0] ADDR_SEG  = 8'h0C;
    localparam logic [7:0] ADDR_VLD  = 8'h10;
    localparam logic [7:0] ADDR_DATA = 8'h14;
    localparam logic [7:0] ADDR_CNT  = 8'h18;

    localparam int TW = (RDY_TIMEOUT > 1) ? $clog2(RDY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(RDY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POLL_VLD,
        RD_DATA,
        CALC,
        POLL_RDY,
        WR_SEG,
        WR_LED,
        WR_CNT
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] acc_calc;
    logic [TW-1:0]         timer;
    logic                  rdy_timeout;

    assign rdy_timeout = (state == POLL_RDY) && !io_din[0] && (timer == TIMER_LAST);

    always_comb begin
        acc_calc = acc;
        case (mode)
            2'b00:   acc_calc = acc + data_q;
            2'b01:   acc_calc = data_q;
            2'b10:   acc_calc = (data_q > acc) ? data_q : acc;
            default: acc_calc = acc ^ data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            data_q <= '0;
            acc    <= '0;
            count  <= '0;
            err    <= 1'b0;
            timer  <= '0;
        end else begin
            state <= state_next;
            if (state == RD_DATA) begin
                data_q <= io_din;
            end
            if (state == CALC) begin
                timer <= '0;
            end else if (state == POLL_RDY && !io_din[0] && !rdy_timeout) begin
                timer <= timer + 1'b1;
            end
            if (rdy_timeout) begin
                err <= 1'b1;
            end
            // clr takes priority over the CALC and WR_LED updates
            if (clr) begin
                acc   <= '0;
                count <= '0;
            end else begin
                if (state == CALC) begin
                    acc <= acc_calc;
                end
                if (state == WR_LED) begin
                    count <= count + 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        io_addr    = ADDR_LED;
        io_dout    = '0;
        io_we      = 1'b0;
        io_rd      = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_next = POLL_VLD;
            end
            POLL_VLD: begin
                // Polling must not raise io_rd: that would consume swx_vld.
                io_addr = ADDR_VLD;
                if (io_din[0])   state_next = RD_DATA;
                else if (!en)    state_next = IDLE;
            end
            RD_DATA: begin
                io_addr    = ADDR_DATA;
                io_rd      = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                state_next = POLL_RDY;
            end
            POLL_RDY: begin
                io_addr = ADDR_RDY;
                if (io_din[0])        state_next = WR_SEG;
                else if (rdy_timeout) state_next = WR_LED;
            end
            WR_SEG: begin
                io_addr    = ADDR_SEG;
                io_we      = 1'b1;
                io_dout    = acc;
                state_next = WR_LED;
            end
            WR_LED: begin
                io_addr    = ADDR_LED;
                io_we      = 1'b1;
                io_dout    = DATA_WIDTH'(acc[15:0]);
                state_next = WR_CNT;
            end
            WR_CNT: begin
                io_addr    = ADDR_CNT;
                io_we      = 1'b1;
                io_dout    = DATA_WIDTH'(count);
                state_next = en ? POLL_VLD : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
